// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register-file write port
// Optional macro ARB_STATS_EN adds stats_clear and per-requester saturating grant_count.
module regfile_write_arbiter #(
  parameter  int N        = 32,
  parameter  int NUM_REQ  = 4,
  parameter  int ADDR_W   = 5,
  parameter  int NUM_REGS = 32,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
`ifdef ARB_STATS_EN
  input  logic                      stats_clear,
  output logic [NUM_REQ*16-1:0]     grant_count,
`endif
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*N-1:0]      req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REGS-1:0]       RegEnable,
  output logic [N-1:0]              WriteData,
  output logic                      addr_error,
  output logic [IDX_W-1:0]          grant_id
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REGS-1:0] reg_enable_q, reg_enable_d;
  logic [N-1:0]        write_data_q, write_data_d;
  logic                addr_error_q, addr_error_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                grant_ok;
  logic                transfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [N-1:0]        sel_data;
  int                  best_off;
  int                  off;

  // Pick the valid requester closest to the pointer, measured upward with wrap.
  always_comb begin
    best_off = NUM_REQ;
    off      = 0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - int'(ptr_q)) % NUM_REQ;
      if (req_valid[i] && off < best_off) begin
        best_off = off;
        sel_idx  = IDX_W'(i);
      end
    end
    sel_found = best_off < NUM_REQ;
  end

  always_comb begin
    grant_ok  = reset && !hold && sel_found;
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        req_ready[i] = grant_ok;
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
        sel_data     = req_data[i*N +: N];
      end
    end
    transfer = |(req_valid & req_ready);
  end

  always_comb begin
    ptr_d        = ptr_q;
    reg_enable_d = '0;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    addr_error_d = addr_error_q;
    if (transfer) begin
      ptr_d        = (sel_idx == IDX_W'(NUM_REQ-1)) ? '0 : sel_idx + IDX_W'(1);
      write_data_d = sel_data;
      grant_id_d   = sel_idx;
      if ({1'b0, sel_addr} >= NUM_REGS_W) begin
        addr_error_d = 1'b1;
      end else begin
        // Bit 0 is left clear so register 0 can never be written.
        for (int r = 1; r < NUM_REGS; r++) begin
          reg_enable_d[r] = (sel_addr == ADDR_W'(r));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q        <= '0;
      reg_enable_q <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
      addr_error_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      reg_enable_q <= reg_enable_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign RegEnable  = reg_enable_q;
  assign WriteData  = write_data_q;
  assign grant_id   = grant_id_q;
  assign addr_error = addr_error_q;

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stats_clear) begin
        count_d[i] = '0;
      end else if (transfer && sel_idx == IDX_W'(i) && count_q[i] != 16'hFFFF) begin
        count_d[i] = count_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign grant_count = count_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter (NUM_REGS=16)
// Build with ARB_STATS_EN defined to also exercise the grant counters.
module tb_regfile_write_arbiter;
  localparam int N = 32, NUM_REQ = 4, ADDR_W = 5, NUM_REGS = 16, IDW = 2;

  logic                      clk = 1'b0;
  logic                      reset, hold;
  logic [NUM_REQ-1:0]        req_valid, req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*N-1:0]      req_data;
  logic [NUM_REGS-1:0]       RegEnable;
  logic [N-1:0]              WriteData;
  logic                      addr_error;
  logic [IDW-1:0]            grant_id;
`ifdef ARB_STATS_EN
  logic                      stats_clear;
  logic [NUM_REQ*16-1:0]     grant_count;
`endif

  regfile_write_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset), .hold(hold),
`ifdef ARB_STATS_EN
    .stats_clear(stats_clear), .grant_count(grant_count),
`endif
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .RegEnable(RegEnable), .WriteData(WriteData), .addr_error(addr_error), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_REGS-1:0] en;
    logic [N-1:0]        data;
    logic [IDW-1:0]      id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   ptr_m = 0;
  logic err_m = 1'b0;

  function automatic int pick(logic [NUM_REQ-1:0] v, int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(int g);
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*N +: N] = d;
  endtask

  // Records the expected registered result of a grant, then advances one cycle.
  task automatic commit(input int g);
    exp_t e;
    logic [ADDR_W-1:0] a;
    if (g >= 0) begin
      a = req_addr[g*ADDR_W +: ADDR_W];
      e.en = '0;
      if (a != 0 && int'(a) < NUM_REGS) e.en = NUM_REGS'(1) << a;
      if (int'(a) >= NUM_REGS) err_m = 1'b1;
      e.data = req_data[g*N +: N];
      e.id = IDW'(g);
      sb.push_back(e);
      ptr_m = (g + 1) % NUM_REQ;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    exp_t e;
    int g;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 1), 32'hA000_0000 + i);
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_checks++; if (RegEnable !== '0) begin n_fail++; $display("FAIL reset_en: got %h want 0", RegEnable); end
    n_checks++; if (WriteData !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", WriteData); end
    n_checks++; if (addr_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", addr_error); end
    n_checks++; if (grant_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", grant_id); end
    reset = 1'b1;
    #1;
    g = pick(req_valid, ptr_m);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b want 0001", req_ready); end
    commit(g);
    e = sb.pop_front();
    n_checks++; if ({RegEnable, WriteData, grant_id} !== e) begin n_fail++; $display("FAIL first_out: got en=%h data=%h id=%0d want en=%h data=%h id=%0d", RegEnable, WriteData, grant_id, e.en, e.data, e.id); end
    req_valid = '0;
    commit(-1);
  endtask

  task automatic test_single;
    exp_t e;
    int g;
    set_req(2, 5, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    #1;
    g = pick(req_valid, ptr_m);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    commit(g);
    req_valid = '0;
    e = sb.pop_front();
    n_checks++; if ({RegEnable, WriteData, grant_id} !== e) begin n_fail++; $display("FAIL single_out: got en=%h data=%h id=%0d want en=%h data=%h id=%0d", RegEnable, WriteData, grant_id, e.en, e.data, e.id); end
    n_checks++; if (RegEnable !== 16'h0020) begin n_fail++; $display("FAIL single_en: got %h want 0020", RegEnable); end
    commit(-1);
    n_checks++; if (RegEnable !== '0) begin n_fail++; $display("FAIL single_pulse: got %h want 0", RegEnable); end
    n_checks++; if (WriteData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold_data: got %h want deadbeef", WriteData); end
  endtask

  task automatic test_fairness;
    exp_t e;
    int g;
    set_req(3, 4, 32'h3333_0000);
    req_valid = 4'b1000;
    #1;
    g = pick(req_valid, ptr_m);
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL fair_pre: got %b want 1000", req_ready); end
    commit(g);
    void'(sb.pop_front());
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 1), 32'h1000_0000 * (i + 1) + k);
      #1;
      g = pick(req_valid, ptr_m);
      n_checks++; if (req_ready !== onehot(k % 4)) begin n_fail++; $display("FAIL fair_ready%0d: got %b want %b", k, req_ready, onehot(k % 4)); end
      commit(g);
      e = sb.pop_front();
      n_checks++; if ({RegEnable, WriteData, grant_id} !== e) begin n_fail++; $display("FAIL fair_out%0d: got en=%h data=%h id=%0d want en=%h data=%h id=%0d", k, RegEnable, WriteData, grant_id, e.en, e.data, e.id); end
      n_checks++; if (RegEnable !== NUM_REGS'(1) << (k % 4 + 1)) begin n_fail++; $display("FAIL fair_en%0d: got %h want bit %0d", k, RegEnable, k % 4 + 1); end
    end
    req_valid = '0;
    commit(-1);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int g;
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_req(1, ADDR_W'(3 + k), 32'hB2B0_0000 + k);
      #1;
      g = pick(req_valid, ptr_m);
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 0010", k, req_ready); end
      commit(g);
      e = sb.pop_front();
      n_checks++; if ({RegEnable, WriteData, grant_id} !== e) begin n_fail++; $display("FAIL b2b_out%0d: got en=%h data=%h id=%0d want en=%h data=%h id=%0d", k, RegEnable, WriteData, grant_id, e.en, e.data, e.id); end
    end
    req_valid = '0;
    commit(-1);
    n_checks++; if (RegEnable !== '0) begin n_fail++; $display("FAIL b2b_idle: got %h want 0", RegEnable); end
  endtask

  task automatic test_addr_range;
    exp_t e;
    int g;
    logic [ADDR_W-1:0] addrs [4];
    logic [N-1:0] datas [4];
    addrs = '{5'd0, 5'd15, 5'd16, 5'd20};
    datas = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0BAD_0001, 32'h0BAD_0002};
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_req(1, addrs[k], datas[k]);
      #1;
      g = pick(req_valid, ptr_m);
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL range_ready%0d: got %b want 0010", k, req_ready); end
      commit(g);
      e = sb.pop_front();
      n_checks++; if ({RegEnable, WriteData, grant_id} !== e) begin n_fail++; $display("FAIL range_out%0d: got en=%h data=%h id=%0d want en=%h data=%h id=%0d", k, RegEnable, WriteData, grant_id, e.en, e.data, e.id); end
      n_checks++; if (addr_error !== err_m) begin n_fail++; $display("FAIL range_err%0d: got %b want %b", k, addr_error, err_m); end
    end
    req_valid = '0;
    repeat (10) commit(-1);
    n_checks++; if (addr_error !== 1'b1) begin n_fail++; $display("FAIL range_sticky: got %b want 1", addr_error); end
    n_checks++; if (RegEnable !== '0) begin n_fail++; $display("FAIL range_idle_en: got %h want 0", RegEnable); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int g;
    set_req(0, 7, 32'h7777_7777);
    req_valid = 4'b0001;
    #1;
    g = pick(req_valid, ptr_m);
    @(posedge clk);
    #2;
    n_checks++; if (RegEnable !== 16'h0080) begin n_fail++; $display("FAIL mid_pulse: got %h want 0080", RegEnable); end
    reset = 1'b0;
    #1;
    n_checks++; if (RegEnable !== '0) begin n_fail++; $display("FAIL mid_clear_en: got %h want 0", RegEnable); end
    n_checks++; if (addr_error !== 1'b0) begin n_fail++; $display("FAIL mid_clear_err: got %b want 0", addr_error); end
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", req_ready); end
    sb.delete();
    ptr_m = 0;
    err_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_req(1, 2, 32'h2222_2222);
    req_valid = 4'b0011;
    #1;
    g = pick(req_valid, ptr_m);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr: got %b want 0001", req_ready); end
    commit(g);
    e = sb.pop_front();
    n_checks++; if ({RegEnable, WriteData, grant_id} !== e) begin n_fail++; $display("FAIL mid_out: got en=%h data=%h id=%0d want en=%h data=%h id=%0d", RegEnable, WriteData, grant_id, e.en, e.data, e.id); end
    req_valid = '0;
    commit(-1);
  endtask

  task automatic test_hold;
    exp_t e;
    int g;
    set_req(3, 9, 32'h9999_0000);
    req_valid = 4'b1000;
    #1;
    g = pick(req_valid, ptr_m);
    commit(g);
    void'(sb.pop_front());
    set_req(0, 10, 32'hAAAA_0000);
    set_req(1, 11, 32'hBBBB_0000);
    req_valid = 4'b0011;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL hold_ready%0d: got %b want 0", k, req_ready); end
      commit(-1);
      n_checks++; if (RegEnable !== '0) begin n_fail++; $display("FAIL hold_en%0d: got %h want 0", k, RegEnable); end
    end
    hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      g = pick(req_valid, ptr_m);
      n_checks++; if (req_ready !== onehot(k)) begin n_fail++; $display("FAIL release_ready%0d: got %b want %b", k, req_ready, onehot(k)); end
      commit(g);
      e = sb.pop_front();
      n_checks++; if ({RegEnable, WriteData, grant_id} !== e) begin n_fail++; $display("FAIL release_out%0d: got en=%h data=%h id=%0d want en=%h data=%h id=%0d", k, RegEnable, WriteData, grant_id, e.en, e.data, e.id); end
    end
    req_valid = '0;
    commit(-1);
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    err_m = 1'b0;
    sb.delete();
    set_req(3, 2, 32'h5151_5151);
    req_valid = 4'b1000;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    n_checks++; if (grant_count[48 +: 16] !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat: got %h want ffff", grant_count[48 +: 16]); end
    n_checks++; if (grant_count[0 +: 48] !== '0) begin n_fail++; $display("FAIL stats_others: got %h want 0", grant_count[0 +: 48]); end
    stats_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stats_clear = 1'b0;
    n_checks++; if (grant_count[48 +: 16] !== 16'h0000) begin n_fail++; $display("FAIL stats_clear: got %h want 0", grant_count[48 +: 16]); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (grant_count[48 +: 16] !== 16'h0001) begin n_fail++; $display("FAIL stats_restart: got %h want 1", grant_count[48 +: 16]); end
    req_valid = '0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    hold = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
`ifdef ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    test_reset;
    test_single;
    test_fairness;
    test_back_to_back;
    test_addr_range;
    test_reset_mid;
    test_hold;
`ifdef ARB_STATS_EN
    test_stats;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the register file among NUM_REQ requesters, e.g. the ALU writeback, the load unit and the link-register write. Uses round-robin arbitration with a valid/ready handshake per requester. The granted write is registered and decoded into the one-hot per-register enable vector that drives the enable input of every register in the file. Register 0 is never written.

Parameters:
N, 32, data width of one register
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register address width
NUM_REGS, 32, number of registers in the file (NUM_REGS <= 2**ADDR_W)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
hold  input  1  pipeline stall; while 1 no request is granted
req_valid  input  NUM_REQ  request i is pending
req_addr  input  NUM_REQ*ADDR_W  packed destination address, slice i belongs to requester i
req_data  input  NUM_REQ*N  packed write data, slice i belongs to requester i
req_ready  output  NUM_REQ  one-hot grant, combinational
RegEnable  output  NUM_REGS  one-hot enable to the register file, registered
WriteData  output  N  data to the register file, registered
addr_error  output  1  sticky flag: an out-of-range address was accepted
grant_id  output  $clog2(NUM_REQ)  index of the last accepted requester, registered

Behaviour:
- Reset (reset==0, asynchronous): RegEnable=0, WriteData=0, addr_error=0, grant_id=0, round-robin pointer=0. While reset is low, req_ready=0.
- Arbitration (combinational):
  - If hold==0, req_ready asserts for the first i with req_valid[i]==1, searching from the pointer upward and wrapping modulo NUM_REQ.
  - At most one bit of req_ready is high. req_ready is 0 when hold==1 or when no request is valid.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high in the same cycle.
- Pointer update: on a transfer from requester i, the pointer becomes (i+1) mod NUM_REQ at the next rising edge. With no transfer the pointer holds.
- Output stage, 1-cycle latency after a transfer at edge t:
  - Valid address a (1 <= a < NUM_REGS): at edge t, RegEnable = 1<<a, WriteData=req_data[i], grant_id=i. The register file captures the data at edge t+1.
  - Address 0: the transfer is accepted (ready high), RegEnable=0, WriteData and grant_id update, no error.
  - Address >= NUM_REGS: the transfer is accepted, RegEnable=0, addr_error is set to 1 and stays 1 until reset.
  - No transfer: RegEnable=0 at the next edge. Every enable pulse lasts exactly one cycle. WriteData and grant_id hold their last value.
- Requesters hold valid, address and data stable until ready is seen. Dropping valid before the grant is legal; that request is simply not granted.
- If hold rises in the same cycle as a request, no transfer occurs and the pointer does not move.
- Reset mid-operation: any pending registered enable is cleared immediately. No partial write reaches the file after reset falls.
- Throughput: one write per cycle. Back-to-back transfers, including from the same requester when it is the only one valid, are allowed.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds output grant_count, width NUM_REQ*16. It holds one 16-bit saturating counter per requester, incremented on each transfer from that requester.
  - The counter stops at 16'hFFFF.
  - It is cleared by reset and by the added input stats_clear (1 bit, synchronous, takes priority over an increment in the same cycle).
- Not defined: no grant_count or stats_clear ports and no counter logic. All other behaviour is identical.

Test Plan:
1. Reset low with req_valid=4'b1111 -> req_ready=0, RegEnable=0, WriteData=0, addr_error=0. After release, the first grant goes to requester 0.
2. Requester 2 valid alone, addr=5, data=32'hDEADBEEF -> req_ready=4'b0100. Next cycle RegEnable=32'h0000_0020, WriteData=32'hDEADBEEF, grant_id=2. The cycle after, RegEnable=0.
3. All four requesters valid for 8 cycles with addrs 1..4 -> grant order 0,1,2,3,0,1,2,3 and RegEnable sequence bit1,bit2,bit3,bit4 repeating.
4. Requester 1 writes addr 0 with 32'hFFFF_FFFF -> accepted, RegEnable stays 0, addr_error=0. With NUM_REGS=16 and addr 20 -> accepted, RegEnable=0, addr_error=1, still 1 after 10 idle cycles.
5. hold=1 for 3 cycles with req_valid=4'b0011 -> req_ready=0 and the pointer is unchanged. On hold=0, requester 0 (if pointer=0) is granted first.
6. ARB_STATS_EN defined: 70000 consecutive grants to requester 3 -> its grant_count slice = 16'hFFFF. stats_clear pulse concurrent with a grant -> the slice reads 0 next cycle.
